// File: rtl/parity_mem_writer_pkg.sv
// -----------------------------------------------------------------------------
// parity_mem_writer_pkg
//   Shared definitions for the parity memory writer:
//     - default data/address widths
//     - FSM state encoding
//     - parity sense helper (even/odd select)
//     - parity bit of the all-zero data word (used to build the clear word)
// -----------------------------------------------------------------------------
package parity_mem_writer_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned AW_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_CLEAR  = 2'd3
  } state_e;

  // Turns the raw XOR reduction of a data word into the stored parity bit.
  function automatic logic apply_sense(input logic even_par, input logic odd);
    return even_par ^ odd;
  endfunction

  // Parity bit that makes an all-zero data word consistent.
  function automatic logic zero_word_par(input logic odd);
    return apply_sense(1'b0, odd);
  endfunction

endpackage

// File: rtl/parity_mem_writer_parity_gen.sv
// -----------------------------------------------------------------------------
// parity_mem_writer_parity_gen
//   Combinational parity generator: XOR-reduce of a DW-bit word with
//   even/odd sense selected by ODD.
//   Ports:
//     data_i  in  DW  word to protect
//     par_o   out 1   parity bit that makes {par_o, data_i} consistent
// -----------------------------------------------------------------------------
module parity_mem_writer_parity_gen
  import parity_mem_writer_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter bit          ODD = 1'b0
) (
  input  logic [DW-1:0] data_i,
  output logic          par_o
);

  assign par_o = apply_sense(^data_i, ODD);

endmodule

// File: rtl/parity_mem_writer.sv
// -----------------------------------------------------------------------------
// parity_mem_writer
//   Write side of a small parity-protected store (2**AW entries of DW+1 bits,
//   word format {parity, data}). Writes arrive over valid/ready, get parity
//   generated, are written, then the entry is re-read and its stored parity
//   is checked. A swept clear rewrites every entry with the consistent zero
//   word. The combinational read view matches the existing ROM readers.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     wr_valid/ready write handshake (ready only in IDLE with clr low)
//     wr_addr/data   write address / data
//     inject_err     captured with the handshake; flips the stored parity bit
//     clr            start a clear sweep (accepted only in IDLE, beats writes)
//     wr_done        one-cycle pulse after a write's verify step
//     busy           FSM not in IDLE
//     perr_sticky    verify mismatch seen since reset/clear
//     perr_addr      address of the latest verify mismatch
//     rd_addr        read address
//     rd_num/parity  data and parity of the addressed entry (combinational)
//     rd_perr        parity mismatch on the addressed entry (combinational)
// -----------------------------------------------------------------------------
module parity_mem_writer
  import parity_mem_writer_pkg::*;
#(
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned AW         = AW_DEF,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          inject_err,
  input  logic          clr,
  output logic          wr_done,
  output logic          busy,
  output logic          perr_sticky,
  output logic [AW-1:0] perr_addr,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_num,
  output logic          rd_parity,
  output logic          rd_perr
);

  localparam int unsigned WORD_W = DW + 1;
  localparam int          DEPTH  = 1 << AW;
  localparam logic [WORD_W-1:0] ZERO_WORD = {zero_word_par(PARITY_ODD), {DW{1'b0}}};
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  state_e              state_q;
  logic [WORD_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]       addr_q;
  logic [DW-1:0]       data_q;
  logic                inj_q;
  logic [AW-1:0]       ptr_q;
  logic                wr_done_q;
  logic                perr_sticky_q;
  logic [AW-1:0]       perr_addr_q;

  logic [WORD_W-1:0]   vword_s;
  logic [WORD_W-1:0]   rword_s;
  logic                par_w_s;
  logic                par_v_s;
  logic                par_r_s;

  // The verify step re-reads the entry that WRITE just stored.
  assign vword_s = mem_q[addr_q];
  assign rword_s = mem_q[rd_addr];

  parity_mem_writer_parity_gen #(.DW(DW), .ODD(PARITY_ODD)) u_gen_wr (
    .data_i (data_q),
    .par_o  (par_w_s)
  );

  parity_mem_writer_parity_gen #(.DW(DW), .ODD(PARITY_ODD)) u_chk_verify (
    .data_i (vword_s[DW-1:0]),
    .par_o  (par_v_s)
  );

  parity_mem_writer_parity_gen #(.DW(DW), .ODD(PARITY_ODD)) u_chk_read (
    .data_i (rword_s[DW-1:0]),
    .par_o  (par_r_s)
  );

  // FSM, storage array and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= ZERO_WORD;
      end
      addr_q        <= '0;
      data_q        <= '0;
      inj_q         <= 1'b0;
      ptr_q         <= '0;
      wr_done_q     <= 1'b0;
      perr_sticky_q <= 1'b0;
      perr_addr_q   <= '0;
    end else begin
      wr_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // clr wins over a simultaneous write (wr_ready is low then).
          if (clr) begin
            state_q       <= ST_CLEAR;
            ptr_q         <= '0;
            perr_sticky_q <= 1'b0;
            perr_addr_q   <= '0;
          end else if (wr_valid) begin
            addr_q  <= wr_addr;
            data_q  <= wr_data;
            inj_q   <= inject_err;
            state_q <= ST_WRITE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          mem_q[addr_q] <= {par_w_s ^ inj_q, data_q};
          state_q       <= ST_VERIFY;
        end
        ST_VERIFY: begin
          if (vword_s[DW] != par_v_s) begin
            perr_sticky_q <= 1'b1;
            perr_addr_q   <= addr_q;
          end else begin
            perr_sticky_q <= perr_sticky_q;
          end
          wr_done_q <= 1'b1;
          state_q   <= ST_IDLE;
        end
        ST_CLEAR: begin
          mem_q[ptr_q] <= ZERO_WORD;
          if (ptr_q == LAST_PTR) begin
            state_q <= ST_IDLE;
          end else begin
            ptr_q <= ptr_q + AW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign wr_ready    = (state_q == ST_IDLE) && !clr;
  assign busy        = (state_q != ST_IDLE);
  assign wr_done     = wr_done_q;
  assign perr_sticky = perr_sticky_q;
  assign perr_addr   = perr_addr_q;

  assign rd_num    = rword_s[DW-1:0];
  assign rd_parity = rword_s[DW];
  assign rd_perr   = (rword_s[DW] != par_r_s);

endmodule
